route_demux4: RTL and testbench

- Registered 1-to-4 demultiplexer with valid/ready handshakes on the input and on each output; the sequential counterpart of the datapath 4:1 select muxes.
- Takes one word per cycle plus a 2-bit destination select and delivers it to one of four consumer ports, such as write-back, forwarding, memory-store and HI/LO paths.
- Each output has a one-entry holding register, so a stalled consumer blocks only its own lane.

---
 rtl/route_demux4.sv | 76 +++++++
 tb/tb_route_demux4.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/route_demux4.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes and a one-entry holding register per lane.
// Optional per-lane delivery counters are enabled by defining ROUTE_DEMUX_COUNT_EN.
module route_demux4 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  input  logic [1:0]         cnt_sel,
  output logic [CNT_W-1:0]   cnt_out
);

  logic [3:0]       r_valid;
  logic [WIDTH-1:0] r_data [4];
  logic             w_accept;
  logic [3:0]       w_enq;
  logic [3:0]       w_deq;

  // A draining lane can take a new word in the same cycle, so out_ready feeds in_ready directly.
  assign in_ready = ~r_valid[in_sel] | out_ready[in_sel];
  assign w_accept = in_valid & in_ready;
  assign w_enq    = {4{w_accept}} & (4'b0001 << in_sel);
  assign w_deq    = r_valid & out_ready;

  // NOTE: the data registers are reset too, so a lane reads 0 after reset instead of stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_enq[i]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= in_data;
        end else if (w_deq[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_valid;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign out_data[g*WIDTH +: WIDTH] = r_data[g];
  end

`ifdef ROUTE_DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_cnt [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_deq[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign cnt_out = r_cnt[cnt_sel];
`else
  logic w_unused_cnt_sel;

  assign w_unused_cnt_sel = ^cnt_sel;
  assign cnt_out          = '0;
`endif

endmodule

// File: tb/tb_route_demux4.sv
// Bench for route_demux4: directed cases followed by randomized traffic checked by a per-lane scoreboard.
module tb_route_demux4;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [1:0]         cnt_sel;
  logic [CNT_W-1:0]   cnt_out;

  int n_checks = 0;
  int n_errors = 0;

  // Words accepted but not yet taken by each consumer, oldest first.
  logic [WIDTH-1:0] exp_q [4][$];
  bit               sb_en = 0;

  route_demux4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  // Advance to 2 time units after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    #1 rst = 1'b1;
    #7 rst = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: mid-cycle, compare every lane with the model and retire words being taken.
  always @(negedge clk) begin
    if (sb_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sb_valid[%0d]", i), WIDTH'(out_valid[i]), WIDTH'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0) begin
          check($sformatf("sb_data[%0d]", i), lane(i), exp_q[i][0]);
          if (out_ready[i]) void'(exp_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_valid;
    bit         pend;
    int         pend_sel;
    bit         model_ready;

    rst = 1'b0; in_valid = 1'b0; in_sel = 2'b00; in_data = '0;
    out_ready = 4'b1111; cnt_sel = 2'b00;

    // Reset then idle.
    do_reset();
    check("reset_valid", WIDTH'(out_valid), 0);
    check("reset_ready", WIDTH'(in_ready), 1);
    for (int i = 0; i < 4; i++) check($sformatf("reset_data[%0d]", i), lane(i), 0);

    // Single route to lane 2, held stable while its consumer stalls.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'b10; in_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0; in_data = 32'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      check("single_valid", WIDTH'(out_valid), 32'h4);
      check("single_data", lane(2), 32'hDEADBEEF);
      tick();
    end
    out_ready = 4'b0100;
    tick();
    check("single_drained", WIDTH'(out_valid), 0);

    // Back-pressure isolation: stalled lane 1 blocks only requests aimed at lane 1.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hAAAA0001;
    tick();
    #1 check("bp_blocked", WIDTH'(in_ready), 0);
    in_sel = 2'b11; in_data = 32'h12345678;
    #1 check("bp_other_lane", WIDTH'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_valid", WIDTH'(out_valid), 32'hA);
    check("bp_lane1", lane(1), 32'hAAAA0001);
    check("bp_lane3", lane(3), 32'h12345678);
    out_ready = 4'b1111;
    tick();
    check("bp_drained", WIDTH'(out_valid), 0);

    // Full-throughput pass-through on lane 0.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h000000A0;
    tick();
    out_ready = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      in_data = WIDTH'(k);
      #1 check("pt_ready", WIDTH'(in_ready), 1);
      check("pt_valid", WIDTH'(out_valid[0]), 1);
      check("pt_data", lane(0), (k == 1) ? 32'hA0 : WIDTH'(k - 1));
      tick();
    end
    in_valid = 1'b0;
    check("pt_last", lane(0), 4);
    tick();
    check("pt_drained", WIDTH'(out_valid), 0);

    // Asynchronous reset with lanes 0 and 3 full.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h11111111;
    tick();
    in_sel = 2'b11; in_data = 32'h33333333;
    tick();
    in_valid = 1'b0;
    check("ar_before", WIDTH'(out_valid), 32'h9);
    #1 rst = 1'b1;
    #1 check("ar_async_drop", WIDTH'(out_valid), 0);
    #3 rst = 1'b0;
    tick();
    tick();
    check("ar_after_valid", WIDTH'(out_valid), 0);
    check("ar_after_lane0", lane(0), 0);
    check("ar_after_lane3", lane(3), 0);

`ifdef ROUTE_DEMUX_COUNT_EN
    // Delivery counters: three words on lane 2, one on lane 0.
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = (k == 3) ? 2'b00 : 2'b10; in_data = WIDTH'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    cnt_sel = 2'b10;
    #1 check("cnt_lane2", WIDTH'(cnt_out), 3);
    cnt_sel = 2'b00;
    #1 check("cnt_lane0", WIDTH'(cnt_out), 1);
    do_reset();
    #1 check("cnt_reset", WIDTH'(cnt_out), 0);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    sb_en = 1;
    pend = 0;
    pend_sel = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (pend) exp_q[pend_sel].push_back(in_data);
      #2;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 4'($urandom_range(0, 15));
      #1;
      // A lane can take a word when the model has nothing waiting there, or the waiting word leaves now.
      model_ready = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
      check("rand_in_ready", WIDTH'(in_ready), WIDTH'(model_ready));
      pend     = in_valid && model_ready;
      pend_sel = int'(in_sel);
    end
    @(posedge clk);
    if (pend) exp_q[pend_sel].push_back(in_data);
    #2;
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    repeat (4) tick();
    sb_en = 0;
    for (int i = 0; i < 4; i++) check($sformatf("drain_empty[%0d]", i), WIDTH'(exp_q[i].size()), 0);
    exp_valid = out_valid;
    check("drain_valid", WIDTH'(exp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
